// File: rtl/uart_tx_buf_pkg.sv
// Shared definitions for the buffered UART transmitter and its receive-side sibling:
// FSM state encoding, data width and the default bit period for the 50 MHz board clock.
// The PARITY state is only reachable when UART_TX_PARITY_EN is defined.
package uart_tx_buf_pkg;

    localparam int DATA_W               = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 434;   // 50 MHz / 115200 baud

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_e;

    // Even parity over one data byte: the bit that makes the total number of ones even.
    function automatic logic even_parity(input logic [DATA_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_buf_if.sv
// Core-side write port of the UART transmitter plus its status and serial line.
// The core drives data/strobe (master); the transmitter owns full/busy/tx (slave).
interface uart_tx_buf_if;
    import uart_tx_buf_pkg::*;

    logic [DATA_W-1:0] data_in;
    logic              wr_en;
    logic              full;
    logic              busy;
    logic              tx;

    modport master (output data_in, output wr_en, input full, input busy, input tx);
    modport slave  (input data_in, input wr_en, output full, output busy, output tx);

endinterface

// File: rtl/uart_tx_buf_sync_fifo.sv
// Single-clock FIFO with registered full flag and occupancy count.
// Head entry is presented combinationally; rd_en_i advances it on the next edge.
// A write while full is ignored; a simultaneous write and read leaves the count unchanged.
module uart_tx_buf_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  rd_en_i,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int                    DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  full_q;
    logic                  push, pop;

    assign push = wr_en_i && !full_q;
    assign pop  = rd_en_i && (count_q != '0);

    // Next pointer and occupancy values from this cycle's push/pop.
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control state: pointers, count and the full flag move together on one edge.
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == DEPTH_CNT);
        end
    end

    // Storage array: written on an accepted push.
    // NOTE: the array is deliberately not reset; entries are only read once the count covers them.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter, 8N1 LSB first (8E1 when UART_TX_PARITY_EN is defined).
// Bytes written through the bus are queued in a small FIFO and serialised onto tx.
// tx is registered from the current FSM state, so the line lags the state by one clock;
// a byte written into an idle block therefore starts its start bit two edges later.
module uart_tx_buf
    import uart_tx_buf_pkg::*;
#(
    parameter int CLKS_PER_BIT    = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_buf_if.slave  bus
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    tx_state_e           state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                baud_done;
    logic                pop;
    logic                push;
    logic [DATA_W-1:0]   fifo_data;
    logic                fifo_full, fifo_empty;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;
`ifdef UART_TX_PARITY_EN
    logic                parity_q, parity_d;
`endif

    uart_tx_buf_sync_fifo #(
        .WIDTH      (DATA_W),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (bus.wr_en),
        .wr_data_i (bus.data_in),
        .rd_en_i   (pop),
        .rd_data_o (fifo_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign push      = bus.wr_en && !fifo_full;
    assign baud_done = (baud_q == BAUD_LAST);

    // Frame sequencer: every state change reloads the baud counter so each bit lasts exactly
    // CLKS_PER_BIT cycles; the end of STOP chains straight into the next START when data waits.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BAUD_ONE;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = even_parity(fifo_data);
`endif
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_data;
`ifdef UART_TX_PARITY_EN
                        parity_d = even_parity(fifo_data);
`endif
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Line level for the state currently being held; registered on the next edge.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // Busy covers queued data, a frame in the FSM, and the final registered stop-bit cycle
    // (state already back in IDLE while tx still holds the last stop period).
    always_comb begin
        busy_d = (state_q != S_IDLE) || (state_d != S_IDLE) || (fifo_count != '0) || push;
    end

    // State, counters, shift register and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.full = fifo_full;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf (CLKS_PER_BIT=4, 4-entry FIFO).
// A frame-level reference model predicts tx, full and busy every cycle; directed scenarios
// are followed by a randomized write/reset phase. Honours UART_TX_PARITY_EN like the RTL.
module tb_uart_tx_buf;

    localparam int C     = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * C;

    logic clk = 1'b0;
    logic reset;
    logic chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    uart_tx_buf_if bus ();

    uart_tx_buf #(
        .CLKS_PER_BIT    (C),
        .FIFO_DEPTH_LOG2 (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_q[$];
    bit          m_active = 1'b0;
    int          m_pos    = 0;
    logic [10:0] m_bits   = '1;
    logic        m_tx = 1'b1, m_full = 1'b0, m_busy = 1'b0;

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    always @(posedge clk) begin : ref_model
        bit         act_before, push_ok, pop_ok;
        logic [7:0] b;
        if (reset) begin
            m_q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_tx     = 1'b1;
            m_full   = 1'b0;
            m_busy   = 1'b0;
        end else begin
            act_before = m_active;
            m_tx = m_active ? m_bits[m_pos / C] : 1'b1;
            if (m_active) begin
                m_pos++;
                if (m_pos == FRAME_CYC) m_active = 1'b0;
            end
            push_ok = bus.wr_en && (m_q.size() < DEPTH);
            pop_ok  = !m_active && (m_q.size() > 0);
            if (pop_ok) begin
                b        = m_q.pop_front();
                m_bits   = frame_of(b);
                m_pos    = 0;
                m_active = 1'b1;
            end
            if (push_ok) m_q.push_back(bus.data_in);
            m_full = (m_q.size() == DEPTH);
            m_busy = (m_q.size() > 0) || act_before || m_active;
        end
    end

    // Cycle-by-cycle comparison of the outputs, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("tx",   32'(bus.tx),   32'(m_tx));
            check("full", 32'(bus.full), 32'(m_full));
            check("busy", 32'(bus.busy), 32'(m_busy));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic we, input logic [7:0] d);
        @(negedge clk);
        bus.wr_en   = we;
        bus.data_in = d;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            bus.wr_en = 1'b0;
            if (!bus.busy && m_q.size() == 0 && !m_active) return;
        end
        check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    // Leaves the bench at a negedge just before an edge on which the transmitter pops.
    task automatic wait_pop(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            bus.wr_en = 1'b0;
            if (m_q.size() > 0 && (!m_active || m_pos == FRAME_CYC - 1)) return;
        end
        check("pop_timeout", 32'(m_q.size()), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.data_in = '0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_tx",   32'(bus.tx),   32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;

        // Single byte: tx falls two edges after the write edge.
        drive(1'b1, 8'hA5);
        drive(1'b0, 8'h00);
        check("lat_n0", 32'(bus.tx), 32'd1);
        @(negedge clk);
        check("lat_n1", 32'(bus.tx), 32'd1);
        @(negedge clk);
        check("lat_n2", 32'(bus.tx), 32'd0);
        wait_idle(200);

        // Back-to-back frames with no idle gap.
        drive(1'b1, 8'h00);
        drive(1'b1, 8'hFF);
        drive(1'b1, 8'h55);
        drive(1'b0, 8'h00);
        check("b2b_full", 32'(bus.full), 32'd0);
        wait_idle(400);

        // Overflow: sixth byte dropped.
        for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'h11 + i));
        drive(1'b0, 8'h00);
        check("ovf_full", 32'(bus.full), 32'd1);

        // Write in the pop cycle while full (dropped), then at three entries (stored).
        wait_pop(200);
        bus.wr_en = 1'b1; bus.data_in = 8'h77;
        drive(1'b0, 8'h00);
        check("wp4_full", 32'(bus.full), 32'd0);
        wait_pop(200);
        bus.wr_en = 1'b1; bus.data_in = 8'h78;
        drive(1'b0, 8'h00);
        check("wp3_full", 32'(bus.full), 32'd0);
        wait_idle(600);

        // Reset in the middle of DATA bit 3; queued bytes vanish.
        drive(1'b1, 8'h3C);
        drive(1'b1, 8'h99);
        drive(1'b1, 8'h9A);
        drive(1'b0, 8'h00);
        for (int i = 0; i < 100; i++) begin
            if (m_active && m_pos == 4 * C + 1) break;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_tx",   32'(bus.tx),   32'd1);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        drive(1'b1, 8'h42);
        drive(1'b0, 8'h00);
        wait_idle(200);

        // Parity-sensitive bytes (odd and even population).
        drive(1'b1, 8'h07);
        drive(1'b0, 8'h00);
        wait_idle(200);
        drive(1'b1, 8'h03);
        drive(1'b0, 8'h00);
        wait_idle(200);

        // Randomized phase: bursts, sparse writes and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            int p;
            p = ((i / 200) % 3 == 0) ? 90 : (((i / 200) % 3 == 1) ? 5 : 40);
            if ($urandom_range(0, 999) < 2) begin
                @(negedge clk);
                reset     = 1'b1;
                bus.wr_en = 1'b0;
                @(negedge clk);
                reset = 1'b0;
            end
            drive(1'($urandom_range(0, 99) < p), 8'($urandom));
        end
        drive(1'b0, 8'h00);
        wait_idle(1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
